// File: rtl/mem_output_arbiter.sv
// mem_output_arbiter: shares one output channel among NUM_PE curr/mem queue
// pipelines. Each round opened by batch_start, every PE is granted exactly
// once in round-robin order, its beats are forwarded, then it is retired.
// Ports: clk/reset_n (sync, active-low); batch_start opens a round;
//   pe_request/pe_valid/pe_finish/pe_data come from the PEs, pe_permit goes
//   back one-hot; out_almost_full is mirrored on stall; out_data/out_valid
//   carry forwarded beats (1-cycle latency); grant_idx/busy/round_done/
//   beat_count report round progress.
module mem_output_arbiter #(
   parameter int NUM_PE = 4,
   parameter int DATA_W = 512
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     batch_start,
   input  logic [NUM_PE-1:0]        pe_request,
   output logic [NUM_PE-1:0]        pe_permit,
   input  logic [NUM_PE*DATA_W-1:0] pe_data,
   input  logic [NUM_PE-1:0]        pe_valid,
   input  logic [NUM_PE-1:0]        pe_finish,
   input  logic                     out_almost_full,
   output logic                     stall,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic [2:0]               grant_idx,
   output logic                     busy,
   output logic                     round_done,
   output logic [15:0]              beat_count
);

   typedef enum logic [2:0] {IDLE, SCAN, GRANT, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [NUM_PE-1:0]   served_q, served_d;
   logic [NUM_PE-1:0]   pe_permit_q, pe_permit_d;
   logic [2:0]          rr_ptr_q, rr_ptr_d;
   logic [2:0]          grant_idx_q, grant_idx_d;
   logic                drain_cnt_q, drain_cnt_d;
   logic                busy_q, busy_d;
   logic                round_done_q, round_done_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [15:0]         beat_count_q, beat_count_d;

   // The downstream FIFO back-pressures every PE directly, no register stage.
   assign stall = out_almost_full;

   // View of the currently granted PE; all other PEs are invisible here.
   logic                sel_valid;
   logic                sel_finish;
   logic [DATA_W-1:0]   sel_data;
   logic [NUM_PE-1:0]   grant_onehot;

   always_comb begin
      sel_valid    = 1'b0;
      sel_finish   = 1'b0;
      sel_data     = '0;
      grant_onehot = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (grant_idx_q == 3'(i)) begin
            sel_valid       = pe_valid[i];
            sel_finish      = pe_finish[i];
            sel_data        = pe_data[i*DATA_W +: DATA_W];
            grant_onehot[i] = 1'b1;
         end
      end
   end

   // Round-robin pick. A PE is eligible if it requests or has already
   // finished (an empty PE still needs its grant so the round can close).
   // Rotating the doubled mask by rr_ptr puts the search start at bit 0, so
   // the lowest set bit of rot is the winner.
   logic [NUM_PE-1:0]   eligible;
   logic [2*NUM_PE-1:0] rot_wide;
   logic [NUM_PE-1:0]   rot;
   logic                scan_hit;
   logic [2:0]          scan_idx;
   logic [3:0]          scan_pos;
   logic [NUM_PE-1:0]   scan_onehot;
   logic [2:0]          next_ptr;

   always_comb begin
      eligible = (pe_request | pe_finish) & ~served_q;
      rot_wide = {eligible, eligible} >> rr_ptr_q;
      rot      = rot_wide[NUM_PE-1:0];
      scan_hit = |rot;
      scan_idx = '0;
      scan_pos = '0;
      for (int k = NUM_PE - 1; k >= 0; k--) begin
         if (rot[k]) begin
            scan_pos = {1'b0, rr_ptr_q} + 4'(k);
            if (scan_pos >= 4'(NUM_PE)) begin
               scan_pos = scan_pos - 4'(NUM_PE);
            end
            scan_idx = scan_pos[2:0];
         end
      end
      scan_onehot = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (scan_idx == 3'(i)) begin
            scan_onehot[i] = scan_hit;
         end
      end
      next_ptr = (grant_idx_q == 3'(NUM_PE - 1)) ? 3'd0 : grant_idx_q + 3'd1;
   end

   always_comb begin
      state_d      = state_q;
      served_d     = served_q;
      pe_permit_d  = pe_permit_q;
      rr_ptr_d     = rr_ptr_q;
      grant_idx_d  = grant_idx_q;
      drain_cnt_d  = drain_cnt_q;
      round_done_d = 1'b0;

      // Beats are captured during GRANT and also during DRAIN so a PE's
      // trailing beat issued alongside finish is not lost. A stalled cycle
      // never captures, because the frozen PE will present that beat again.
      out_valid_d = sel_valid & ~stall & ((state_q == GRANT) || (state_q == DRAIN));
      out_data_d  = sel_data;

      beat_count_d = beat_count_q;
      if (out_valid_d && (beat_count_q != 16'hFFFF)) begin
         beat_count_d = beat_count_q + 16'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (batch_start) begin
               served_d     = '0;
               beat_count_d = '0;
               rr_ptr_d     = '0;
               state_d      = SCAN;
            end
         end
         SCAN: begin
            if (scan_hit) begin
               grant_idx_d = scan_idx;
               pe_permit_d = scan_onehot;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (sel_finish && !stall) begin
               pe_permit_d = '0;
               served_d    = served_q | grant_onehot;
               drain_cnt_d = 1'b0;
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            // Two unstalled cycles; a stalled cycle does not count.
            if (!stall) begin
               if (drain_cnt_q) begin
                  if (&served_q) begin
                     state_d      = DONE;
                     round_done_d = 1'b1;
                  end else begin
                     rr_ptr_d = next_ptr;
                     state_d  = SCAN;
                  end
               end else begin
                  drain_cnt_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SCAN) || (state_d == GRANT) || (state_d == DRAIN);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         served_q     <= '0;
         pe_permit_q  <= '0;
         rr_ptr_q     <= '0;
         grant_idx_q  <= '0;
         drain_cnt_q  <= 1'b0;
         busy_q       <= 1'b0;
         round_done_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         beat_count_q <= '0;
      end else begin
         state_q      <= state_d;
         served_q     <= served_d;
         pe_permit_q  <= pe_permit_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_idx_q  <= grant_idx_d;
         drain_cnt_q  <= drain_cnt_d;
         busy_q       <= busy_d;
         round_done_q <= round_done_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         beat_count_q <= beat_count_d;
      end
   end

   assign pe_permit  = pe_permit_q;
   assign grant_idx  = grant_idx_q;
   assign busy       = busy_q;
   assign round_done = round_done_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign beat_count = beat_count_q;

endmodule

// File: tb/tb_mem_output_arbiter.sv
// Bench for mem_output_arbiter: behavioural PEs hand beats to the arbiter,
// each accepted beat is queued as expected output, expected grant order is
// queued per round, and a negedge monitor compares everything the DUT emits.
module tb_mem_output_arbiter;

   localparam int NUM_PE = 4;
   localparam int DATA_W = 512;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     batch_start;
   logic [NUM_PE-1:0]        pe_request;
   logic [NUM_PE-1:0]        pe_permit;
   logic [NUM_PE*DATA_W-1:0] pe_data;
   logic [NUM_PE-1:0]        pe_valid;
   logic [NUM_PE-1:0]        pe_finish;
   logic                     out_almost_full;
   logic                     stall;
   logic [DATA_W-1:0]        out_data;
   logic                     out_valid;
   logic [2:0]               grant_idx;
   logic                     busy;
   logic                     round_done;
   logic [15:0]              beat_count;

   mem_output_arbiter #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset_n(reset_n), .batch_start(batch_start),
      .pe_request(pe_request), .pe_permit(pe_permit), .pe_data(pe_data),
      .pe_valid(pe_valid), .pe_finish(pe_finish),
      .out_almost_full(out_almost_full), .stall(stall),
      .out_data(out_data), .out_valid(out_valid), .grant_idx(grant_idx),
      .busy(busy), .round_done(round_done), .beat_count(beat_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard state
   logic [DATA_W-1:0] exp_q[$];
   int                exp_grant[$];
   logic [DATA_W-1:0] aa_pat;
   int                aa_seen = 0;
   int                rd_count = 0;
   bit                rd_seen = 0;
   logic [DATA_W-1:0] mon_exp;
   logic [NUM_PE-1:0] prev_permit = '0;
   logic              prev_af = 1'b0;

   // Behavioural PE state
   int                nb[NUM_PE];
   int                sent[NUM_PE];
   bit                act[NUM_PE];
   bit                rogue[NUM_PE];
   logic [DATA_W-1:0] base[NUM_PE];
   bit                bubbles = 0;
   int                stall_odds = 0;
   int                af_hold = 0;
   int                stall_at = -1;
   int                mid_batch_at = -1;
   int                late_pe = -1;
   bit [NUM_PE-1:0]   late_mask = '0;
   int                round_pushed = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic chk_data(input string name, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [DATA_W-1:0] beat_val(input int i, input int s);
      logic [DATA_W-1:0] v;
      v        = base[i];
      v[15:8]  = 8'(i);
      v[7:0]   = 8'(s);
      return v;
   endfunction

   // Monitor: compares every DUT output against the expectations queued by
   // the stimulus side.
   always @(negedge clk) begin
      chk("stall_mirror", int'(stall), int'(out_almost_full));
      if (prev_af) chk("valid_after_stall", int'(out_valid), 0);
      if (out_valid) begin
         if (out_data == aa_pat) aa_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk_data("beat_data", out_data, mon_exp);
         end
      end
      chk("permit_onehot0", int'($onehot0(pe_permit)), 1);
      if (pe_permit != '0) begin
         chk("permit_vs_idx", int'(pe_permit), 1 << grant_idx);
         chk("busy_in_grant", int'(busy), 1);
         if (prev_permit == '0) begin
            if (exp_grant.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: got PE %0d expected none", grant_idx);
            end else begin
               chk("grant_order", int'(grant_idx), exp_grant.pop_front());
            end
         end
      end
      if (round_done) begin
         rd_count++;
         rd_seen = 1;
         chk("busy_low_at_done", int'(busy), 0);
      end
      prev_permit = pe_permit;
      prev_af     = out_almost_full;
   end

   task automatic drive_pes();
      for (int i = 0; i < NUM_PE; i++) begin
         if (rogue[i]) begin
            // Finish-only PE that also drives junk while PE0 owns the channel.
            pe_request[i] = 1'b0;
            pe_finish[i]  = act[i];
            pe_valid[i]   = act[i] & pe_permit[0];
            pe_data[i*DATA_W +: DATA_W] = aa_pat;
         end else if (act[i]) begin
            pe_request[i] = (sent[i] < nb[i]);
            pe_finish[i]  = (sent[i] >= nb[i]);
            pe_valid[i]   = (sent[i] < nb[i]) && (!bubbles || $urandom_range(3, 0) != 0);
            pe_data[i*DATA_W +: DATA_W] = beat_val(i, sent[i]);
         end else begin
            pe_request[i] = 1'b0;
            pe_finish[i]  = 1'b0;
            pe_valid[i]   = 1'b0;
            pe_data[i*DATA_W +: DATA_W] = '0;
         end
      end
   endtask

   // One clock: decide which PE beat the channel accepts at the coming edge,
   // then after the edge advance the PEs and queue the accepted beat.
   task automatic cycle();
      logic [NUM_PE-1:0] take;
      @(negedge clk);
      take = pe_permit & pe_valid & {NUM_PE{~out_almost_full & reset_n}};
      @(posedge clk);
      #1;
      batch_start = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (take[i] && !rogue[i]) begin
            exp_q.push_back(beat_val(i, sent[i]));
            sent[i]++;
            round_pushed++;
         end
      end
      if (late_pe >= 0 && pe_permit[late_pe]) begin
         for (int i = 0; i < NUM_PE; i++) if (late_mask[i]) act[i] = 1;
         late_pe = -1;
      end
      if (af_hold > 0) begin
         out_almost_full = 1'b1;
         af_hold--;
      end else begin
         out_almost_full = (stall_odds != 0) && ($urandom_range(stall_odds - 1, 0) == 0);
      end
      if (stall_at >= 0 && round_pushed >= stall_at) begin
         out_almost_full = 1'b1;
         af_hold  = 4;
         stall_at = -1;
      end
      if (mid_batch_at >= 0 && round_pushed >= mid_batch_at) begin
         batch_start  = 1'b1;
         mid_batch_at = -1;
      end
      drive_pes();
   endtask

   task automatic clear_pes();
      for (int i = 0; i < NUM_PE; i++) begin
         nb[i] = 0; sent[i] = 0; act[i] = 0; rogue[i] = 0;
         for (int w = 0; w < DATA_W / 32; w++) base[i][w*32 +: 32] = $urandom;
      end
      late_pe = -1; late_mask = '0; stall_at = -1; mid_batch_at = -1;
      af_hold = 0; stall_odds = 0; bubbles = 0;
   endtask

   task automatic run_round(input string name, input int exp_total);
      int n;
      int rd_start;
      rd_start     = rd_count;
      rd_seen      = 0;
      round_pushed = 0;
      batch_start  = 1'b1;
      drive_pes();
      n = 0;
      while (!rd_seen && n < 1000) begin
         cycle();
         n++;
      end
      chk({name, "_round_done_seen"}, int'(rd_seen), 1);
      for (int i = 0; i < NUM_PE; i++) begin act[i] = 0; rogue[i] = 0; end
      stall_odds = 0; af_hold = 0;
      repeat (3) cycle();
      out_almost_full = 1'b0;
      chk({name, "_beat_count"}, int'(beat_count), round_pushed);
      if (exp_total >= 0) chk({name, "_beat_total"}, int'(beat_count), exp_total);
      chk({name, "_done_pulses"}, rd_count - rd_start, 1);
      chk({name, "_busy_idle"}, int'(busy), 0);
      chk({name, "_beats_left"}, exp_q.size(), 0);
      chk({name, "_grants_left"}, exp_grant.size(), 0);
      exp_q.delete();
      exp_grant.delete();
   endtask

   initial begin
      int n;
      aa_pat          = {(DATA_W / 8){8'hAA}};
      reset_n         = 1'b0;
      batch_start     = 1'b0;
      out_almost_full = 1'b0;
      pe_request      = '0;
      pe_valid        = '0;
      pe_finish       = '0;
      pe_data         = '0;
      clear_pes();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_permit", int'(pe_permit), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk_data("rst_out_data", out_data, '0);
      chk("rst_grant_idx", int'(grant_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_round_done", int'(round_done), 0);
      chk("rst_beat_count", int'(beat_count), 0);
      reset_n = 1'b1;
      repeat (2) cycle();

      // All PEs request, 3 beats each: grants 0..3, 12 beats.
      clear_pes();
      for (int i = 0; i < NUM_PE; i++) begin nb[i] = 3; act[i] = 1; exp_grant.push_back(i); end
      run_round("basic", 12);

      // Only PE2 at first; the rest join once PE2 holds the grant.
      clear_pes();
      nb[2] = 2; act[2] = 1;
      nb[0] = 2; nb[1] = 1; nb[3] = 3;
      late_mask = 4'b1011; late_pe = 2;
      exp_grant.push_back(2); exp_grant.push_back(3);
      exp_grant.push_back(0); exp_grant.push_back(1);
      run_round("wrap", 8);

      // 5-cycle almost_full burst mid-stream plus an ignored batch_start.
      clear_pes();
      for (int i = 0; i < NUM_PE; i++) begin nb[i] = 4; act[i] = 1; exp_grant.push_back(i); end
      stall_at = 3; mid_batch_at = 6;
      run_round("stall", 16);

      // PE1 is empty but drives 0xAA.. with valid while PE0 is granted.
      clear_pes();
      nb[0] = 3; nb[2] = 2; nb[3] = 1;
      for (int i = 0; i < NUM_PE; i++) begin act[i] = 1; exp_grant.push_back(i); end
      rogue[1] = 1;
      aa_seen  = 0;
      run_round("rogue", 6);
      chk("rogue_aa_never_out", aa_seen, 0);

      // Randomised rounds: beat counts (0 = finish-only), bubbles, stalls.
      for (int r = 0; r < 15; r++) begin
         clear_pes();
         bubbles    = 1;
         stall_odds = 6;
         for (int i = 0; i < NUM_PE; i++) begin
            nb[i] = $urandom_range(5, 0); act[i] = 1; exp_grant.push_back(i);
         end
         if ($urandom_range(1, 0) == 1) mid_batch_at = 2;
         run_round("random", -1);
      end

      // Reset while PE1 is granted.
      clear_pes();
      nb[0] = 1; nb[1] = 10;
      for (int i = 0; i < NUM_PE; i++) act[i] = 1;
      exp_grant.push_back(0); exp_grant.push_back(1);
      batch_start = 1'b1;
      drive_pes();
      n = 0;
      while (!pe_permit[1] && n < 200) begin cycle(); n++; end
      chk("rst_mid_reached_pe1", int'(pe_permit[1]), 1);
      repeat (2) cycle();
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      chk("rst_mid_permit", int'(pe_permit), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_out_valid", int'(out_valid), 0);
      chk("rst_mid_beat_count", int'(beat_count), 0);
      for (int i = 0; i < NUM_PE; i++) act[i] = 0;
      exp_grant.delete();
      drive_pes();
      repeat (4) cycle();
      chk("rst_mid_beats_left", exp_q.size(), 0);
      exp_q.delete();
      clear_pes();
      for (int i = 0; i < NUM_PE; i++) begin nb[i] = 2; act[i] = 1; exp_grant.push_back(i); end
      run_round("after_reset", 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
